// File: rtl/viterbi_decode.sv
// viterbi_decode
// Hard-decision Viterbi decoder for the rate-1/2, K=3 convolutional code with
// generators 7/5 (octal). Survivors use register exchange, so the decode latency
// is fixed at TB_DEPTH accepted symbols.
//
// Parameters
//   TB_DEPTH      survivor length in symbols and decode latency (8..32)
//   METRIC_W      path-metric width in bits (>= 4)
// Ports
//   clk_sig       in   system clock
//   reset_sig     in   asynchronous active-low reset
//   in_valid      in   encode_sig carries a symbol this cycle
//   encode_sig    in   received symbol, [1] = g1 (111), [0] = g2 (101)
//   decode_sig    out  decoded information bit (registered)
//   decode_valid  out  one-cycle pulse when decode_sig is new (registered)
module viterbi_decode #(
    parameter int TB_DEPTH = 16,
    parameter int METRIC_W = 5
) (
    input  logic       clk_sig,
    input  logic       reset_sig,
    input  logic       in_valid,
    input  logic [1:0] encode_sig,
    output logic       decode_sig,
    output logic       decode_valid
);

    localparam int CNT_W = $clog2(TB_DEPTH + 1);
    localparam logic [CNT_W-1:0]    FILL_FULL = CNT_W'(TB_DEPTH);
    localparam logic [METRIC_W:0]   PM_SAT    = {1'b0, {METRIC_W{1'b1}}};
    localparam logic [METRIC_W-1:0] PM_INIT   = {1'b1, {(METRIC_W-1){1'b0}}};

    logic [METRIC_W-1:0] r_pm   [4];
    logic [TB_DEPTH-1:0] r_surv [4];
    logic [CNT_W-1:0]    r_fill;
    logic                r_dec;
    logic                r_dec_valid;

    logic [METRIC_W:0]   w_cand     [4][2];
    logic [METRIC_W:0]   w_acs      [4];
    logic [METRIC_W:0]   w_norm     [4];
    logic [METRIC_W-1:0] w_pm_nxt   [4];
    logic [TB_DEPTH-1:0] w_surv_nxt [4];
    logic [3:0]          w_sel;
    logic [METRIC_W:0]   w_min;
    logic [1:0]          w_best;
    logic [1:0]          w_exp;
    logic [1:0]          w_bm;
    logic [1:0]          w_pred;

    // New state ns = {s0, u}; its predecessors are {p, s0} for p = 0, 1.
    always_comb begin
        w_exp  = '0;
        w_bm   = '0;
        w_pred = '0;
        w_sel  = '0;
        for (int ns = 0; ns < 4; ns++) begin
            for (int p = 0; p < 2; p++) begin
                w_pred = {p[0], ns[1]};
                w_exp  = {ns[0] ^ ns[1] ^ p[0], ns[0] ^ p[0]};
                w_bm   = {1'b0, encode_sig[1] ^ w_exp[1]} + {1'b0, encode_sig[0] ^ w_exp[0]};
                w_cand[ns][p] = {1'b0, r_pm[w_pred]} + {{(METRIC_W-1){1'b0}}, w_bm};
            end
            // Strict compare: ties keep the s1 = 0 predecessor.
            w_sel[ns] = (w_cand[ns][1] < w_cand[ns][0]);
            w_acs[ns] = w_sel[ns] ? w_cand[ns][1] : w_cand[ns][0];
        end

        w_min = w_acs[0];
        for (int i = 1; i < 4; i++) begin
            if (w_acs[i] < w_min) begin
                w_min = w_acs[i];
            end
        end

        for (int ns = 0; ns < 4; ns++) begin
            w_norm[ns]     = w_acs[ns] - w_min;
            w_pm_nxt[ns]   = (w_norm[ns] > PM_SAT) ? PM_SAT[METRIC_W-1:0]
                                                   : w_norm[ns][METRIC_W-1:0];
            w_surv_nxt[ns] = {r_surv[{w_sel[ns], ns[1]}][TB_DEPTH-2:0], ns[0]};
        end
    end

    // Best state on the pre-update metrics; strict compare favours the lowest index.
    always_comb begin
        w_best = 2'd0;
        for (int s = 1; s < 4; s++) begin
            if (r_pm[s] < r_pm[w_best]) begin
                w_best = 2'(s);
            end
        end
    end

    always_ff @(posedge clk_sig or negedge reset_sig) begin
        if (!reset_sig) begin
            r_pm[0]     <= '0;
            for (int s = 1; s < 4; s++) begin
                r_pm[s] <= PM_INIT;
            end
            for (int s = 0; s < 4; s++) begin
                r_surv[s] <= '0;
            end
            r_fill      <= '0;
            r_dec       <= 1'b0;
            r_dec_valid <= 1'b0;
        end else begin
            r_dec_valid <= 1'b0;
            if (in_valid) begin
                for (int s = 0; s < 4; s++) begin
                    r_pm[s]   <= w_pm_nxt[s];
                    r_surv[s] <= w_surv_nxt[s];
                end
                if (r_fill == FILL_FULL) begin
                    r_dec       <= r_surv[w_best][TB_DEPTH-1];
                    r_dec_valid <= 1'b1;
                end else begin
                    r_fill <= r_fill + CNT_W'(1);
                end
            end
        end
    end

    assign decode_sig   = r_dec;
    assign decode_valid = r_dec_valid;

endmodule

// File: tb/tb_viterbi_decode.sv
// Self-checking bench for viterbi_decode. The reference is the code definition
// (a behavioural encoder) plus the fixed-latency rule: every decoded bit equals
// the information bit sent TB_DEPTH accepted symbols earlier.
module tb_viterbi_decode;

    localparam int TB_DEPTH = 16;
    localparam int METRIC_W = 5;
    localparam int NBITS    = 2048;

    logic       clk_sig = 1'b0;
    logic       reset_sig;
    logic       in_valid;
    logic [1:0] encode_sig;
    logic       decode_sig;
    logic       decode_valid;

    int n_checks = 0;
    int n_fail   = 0;
    bit info [NBITS];

    always #5 clk_sig = ~clk_sig;

    viterbi_decode #(
        .TB_DEPTH (TB_DEPTH),
        .METRIC_W (METRIC_W)
    ) dut (
        .clk_sig      (clk_sig),
        .reset_sig    (reset_sig),
        .in_valid     (in_valid),
        .encode_sig   (encode_sig),
        .decode_sig   (decode_sig),
        .decode_valid (decode_valid)
    );

    // Encoder state st = 2*s1 + s0.
    function automatic logic [1:0] code_sym(input int u, input int st);
        int s1 = st / 2;
        int s0 = st % 2;
        logic g1 = ((u + s0 + s1) % 2) == 1;
        logic g2 = ((u + s1) % 2) == 1;
        return {g1, g2};
    endfunction

    function automatic int next_st(input int u, input int st);
        return 2 * (st % 2) + u;
    endfunction

    task automatic fill_random();
        for (int i = 0; i < NBITS; i++) info[i] = 1'($urandom % 2);
    endtask

    task automatic clock_in(input logic v, input logic [1:0] sym,
                            output logic dv, output logic ds);
        @(negedge clk_sig);
        in_valid   = v;
        encode_sig = sym;
        @(posedge clk_sig);
        #1;
        dv = decode_valid;
        ds = decode_sig;
    endtask

    task automatic apply_reset();
        @(negedge clk_sig);
        in_valid   = 1'b0;
        encode_sig = 2'b00;
        reset_sig  = 1'b0;
        @(negedge clk_sig);
        reset_sig  = 1'b1;
    endtask

    task automatic test_reset();
        logic dv, ds;
        in_valid   = 1'b0;
        encode_sig = 2'b00;
        reset_sig  = 1'b0;
        #2;
        n_checks += 2;
        if (decode_valid !== 1'b0) begin
            n_fail++; $display("FAIL reset_valid: got %b expected 0", decode_valid);
        end
        if (decode_sig !== 1'b0) begin
            n_fail++; $display("FAIL reset_sig: got %b expected 0", decode_sig);
        end
        @(negedge clk_sig);
        reset_sig = 1'b1;
        for (int i = 0; i < 3; i++) begin
            clock_in(1'b0, 2'b11, dv, ds);
            n_checks++;
            if (dv !== 1'b0 || ds !== 1'b0) begin
                n_fail++; $display("FAIL reset_idle: got v=%b d=%b expected v=0 d=0", dv, ds);
            end
        end
    endtask

    task automatic test_all_zero();
        logic dv, ds;
        apply_reset();
        for (int k = 0; k < 40; k++) begin
            clock_in(1'b1, 2'b00, dv, ds);
            n_checks += 2;
            if (dv !== logic'(k >= TB_DEPTH)) begin
                n_fail++; $display("FAIL zero_valid k=%0d: got %b expected %b", k, dv, k >= TB_DEPTH);
            end
            if (ds !== 1'b0) begin
                n_fail++; $display("FAIL zero_bit k=%0d: got %b expected 0", k, ds);
            end
        end
    endtask

    task automatic test_impulse();
        logic dv, ds;
        int st = 0;
        int u;
        apply_reset();
        for (int k = 0; k < 40; k++) begin
            u = (k == 0) ? 1 : 0;
            clock_in(1'b1, code_sym(u, st), dv, ds);
            st = next_st(u, st);
            n_checks++;
            if (dv !== logic'(k >= TB_DEPTH)) begin
                n_fail++; $display("FAIL impulse_valid k=%0d: got %b expected %b", k, dv, k >= TB_DEPTH);
            end
            if (k >= TB_DEPTH) begin
                n_checks++;
                if (ds !== logic'(k == TB_DEPTH)) begin
                    n_fail++; $display("FAIL impulse_bit k=%0d: got %b expected %b", k, ds, k == TB_DEPTH);
                end
            end
        end
    endtask

    task automatic test_error_free();
        logic dv, ds;
        int st = 0;
        int errs = 0;
        apply_reset();
        fill_random();
        for (int k = 0; k < NBITS; k++) begin
            clock_in(1'b1, code_sym(int'(info[k]), st), dv, ds);
            st = next_st(int'(info[k]), st);
            n_checks++;
            if (dv !== logic'(k >= TB_DEPTH)) begin
                n_fail++; $display("FAIL clean_valid k=%0d: got %b expected %b", k, dv, k >= TB_DEPTH);
            end
            if (k >= TB_DEPTH) begin
                n_checks++;
                if (ds !== info[k-TB_DEPTH]) begin
                    n_fail++; errs++;
                    $display("FAIL clean_bit k=%0d: got %b expected %b", k, ds, info[k-TB_DEPTH]);
                end
            end
        end
    endtask

    task automatic test_single_error();
        logic dv, ds;
        logic [1:0] sym;
        int st = 0;
        apply_reset();
        fill_random();
        for (int k = 0; k < NBITS; k++) begin
            sym = code_sym(int'(info[k]), st);
            st  = next_st(int'(info[k]), st);
            if (k % 20 == 19) sym[$urandom % 2] ^= 1'b1;
            clock_in(1'b1, sym, dv, ds);
            n_checks++;
            if (dv !== logic'(k >= TB_DEPTH)) begin
                n_fail++; $display("FAIL err_valid k=%0d: got %b expected %b", k, dv, k >= TB_DEPTH);
            end
            if (k >= TB_DEPTH) begin
                n_checks++;
                if (ds !== info[k-TB_DEPTH]) begin
                    n_fail++; $display("FAIL err_bit k=%0d: got %b expected %b", k, ds, info[k-TB_DEPTH]);
                end
            end
        end
    endtask

    task automatic test_stall();
        logic dv, ds;
        logic exp_ds = 1'b0;
        int st = 0;
        int n_valid = 0;
        int gap;
        apply_reset();
        fill_random();
        for (int k = 0; k < NBITS; k++) begin
            gap = $urandom_range(0, 5);
            for (int g = 0; g < gap; g++) begin
                clock_in(1'b0, 2'($urandom), dv, ds);
                n_checks++;
                if (dv !== 1'b0 || ds !== exp_ds) begin
                    n_fail++;
                    $display("FAIL stall_hold k=%0d: got v=%b d=%b expected v=0 d=%b", k, dv, ds, exp_ds);
                end
            end
            clock_in(1'b1, code_sym(int'(info[k]), st), dv, ds);
            st = next_st(int'(info[k]), st);
            if (dv === 1'b1) n_valid++;
            if (k >= TB_DEPTH) begin
                exp_ds = info[k-TB_DEPTH];
                n_checks++;
                if (dv !== 1'b1 || ds !== exp_ds) begin
                    n_fail++;
                    $display("FAIL stall_bit k=%0d: got v=%b d=%b expected v=1 d=%b", k, dv, ds, exp_ds);
                end
            end
        end
        n_checks++;
        if (n_valid != NBITS - TB_DEPTH) begin
            n_fail++; $display("FAIL stall_count: got %0d expected %0d", n_valid, NBITS - TB_DEPTH);
        end
    endtask

    task automatic test_reset_mid();
        logic dv, ds;
        int st = 0;
        apply_reset();
        fill_random();
        for (int k = 0; k < 100; k++) begin
            clock_in(1'b1, code_sym(int'(info[k]), st), dv, ds);
            st = next_st(int'(info[k]), st);
            if (k >= TB_DEPTH) begin
                n_checks++;
                if (dv !== 1'b1 || ds !== info[k-TB_DEPTH]) begin
                    n_fail++;
                    $display("FAIL mid_pre k=%0d: got v=%b d=%b expected v=1 d=%b", k, dv, ds, info[k-TB_DEPTH]);
                end
            end
        end
        @(negedge clk_sig);
        in_valid  = 1'b0;
        reset_sig = 1'b0;
        #1;
        n_checks++;
        if (decode_valid !== 1'b0 || decode_sig !== 1'b0) begin
            n_fail++;
            $display("FAIL mid_async: got v=%b d=%b expected v=0 d=0", decode_valid, decode_sig);
        end
        @(negedge clk_sig);
        reset_sig = 1'b1;
        fill_random();
        st = 0;
        for (int k = 0; k < 200; k++) begin
            clock_in(1'b1, code_sym(int'(info[k]), st), dv, ds);
            st = next_st(int'(info[k]), st);
            n_checks++;
            if (k < TB_DEPTH) begin
                if (dv !== 1'b0) begin
                    n_fail++; $display("FAIL mid_fill k=%0d: got v=%b expected v=0", k, dv);
                end
            end else if (dv !== 1'b1 || ds !== info[k-TB_DEPTH]) begin
                n_fail++;
                $display("FAIL mid_post k=%0d: got v=%b d=%b expected v=1 d=%b", k, dv, ds, info[k-TB_DEPTH]);
            end
        end
    endtask

    initial begin
        test_reset();
        test_all_zero();
        test_impulse();
        test_error_free();
        test_single_error();
        test_stall();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/viterbi_decode.md
# viterbi_decode

Hard-decision Viterbi decoder for the (2, 1, 2) convolutional code, constraint length 3, generators 7/5 octal. It recovers the information bit stream from 2-bit code symbols. It sits on the receive side of the ConvCode chain, after any channel/noise model and serial-to-parallel regrouping. Survivors are held with the register-exchange method, which gives a fixed decode latency.

## Interface
- `TB_DEPTH`, default 16: survivor length in symbols, which is also the decode latency in accepted symbols. Legal range 8–32.
- `METRIC_W`, default 5: path-metric width in bits; minimum 4.
- `clk_sig`  input  1  system clock.
- `reset_sig`  input  1  reset. One clock; reset is asynchronous and active-low.
- `in_valid`  input  1  `encode_sig` holds a symbol this cycle.
- `encode_sig`  input  2  received code symbol. `[1]` = g1 (111), `[0]` = g2 (101).
- `decode_sig`  output  1  decoded information bit.
- `decode_valid`  output  1  one-cycle pulse when `decode_sig` is new.

## Operation
- **Code definition**
  - Encoder state s = {s1, s0}: s0 = previous input bit, s1 = the bit before that.
  - Code bits for input u: g1 = u^s0^s1, g2 = u^s1.
  - Next state = {s0, u}. State index = 2*s1 + s0, range 0–3.
- **Branch metric:** Hamming distance between `encode_sig` and the expected {g1, g2}, range 0–2.
- **Add-compare-select (ACS)**
  - Each new state {s0, u} has two predecessors, {0, s0} and {1, s0}.
  - Candidate = predecessor metric + branch metric, computed at METRIC_W+1 bits.
  - Keep the smaller candidate. On a tie, pick the predecessor with s1 = 0.
- **Normalization**
  - Subtract the minimum of the four new metrics from all four, so at least one metric is 0.
  - Then saturate each metric to 2^METRIC_W−1.
- **Survivors**
  - New survivor = {selected predecessor's survivor[TB_DEPTH−2:0], u}. Bit 0 is the newest bit.
- **Output selection**
  - Best state = lowest pre-update metric; ties go to the lowest state index.
  - Emitted bit = that state's survivor[TB_DEPTH−1], taken before the update.
- **Fill counter**
  - Counts accepted symbols and saturates at TB_DEPTH.
  - Output is valid only once the count equals TB_DEPTH before the current accept.
- **Stall:** when `in_valid` = 0, metrics, survivors, the fill counter and `decode_sig` all hold.
- **No tail handling:** the stream is treated as continuous. Bits still in the survivors are never flushed.

## Timing
- **Reset values**
  - Metric[0] = 0; metrics[1..3] = 2^(METRIC_W−1).
  - Survivors all 0; fill count 0.
  - `decode_sig` = 0, `decode_valid` = 0.
- **Accept:** a symbol is accepted on the rising edge where `in_valid` = 1. ACS, normalization and survivor update complete at that edge; single-cycle throughput.
- **Output**
  - On the edge accepting symbol k (0-based since reset), if k ≥ TB_DEPTH: `decode_sig` <= estimate of info bit k−TB_DEPTH, and `decode_valid` <= 1.
  - Otherwise `decode_valid` <= 0.
  - Both outputs are registered.
- **Latency:** the bit for symbol n appears in the cycle after symbol n+TB_DEPTH is accepted.
- **Gaps in input:** `decode_valid` is 0 in every cycle following a non-accept edge. Bubbles of any length do not change the decoded sequence.
- **Back-to-back input:** continuous `in_valid` gives continuous `decode_valid` after fill.
- **Reset mid-stream**
  - All state returns to reset values immediately (asynchronous).
  - The fill counter restarts, so the next TB_DEPTH accepted symbols produce no output.
- **Metric bounds:** metrics never wrap. For METRIC_W ≥ 4, the saturation value is never reached on reachable paths once past the first 2 symbols after reset.

## Test plan
- **All-zero stream:** 40 symbols of 00 with `in_valid` held high.
  - `decode_valid` = 0 for the first 16 accept edges, then 1 on every edge.
  - `decode_sig` = 0 throughout.
- **Impulse:** send 11, 10, 11, then 37 × 00.
  - First valid output = 1.
  - All following outputs = 0.
- **Error-free random stream:** 2048 random bits encoded per the code definition.
  - Output matches the input delayed by 16 symbols, bit-exact, zero mismatches.
- **Single-error correction:** same stream with one bit of `encode_sig` flipped at every 20th symbol.
  - Zero output errors.
- **Stall:** random 0–5 cycle `in_valid` gaps inserted into the error-free stream.
  - Identical decoded sequence.
  - `decode_valid` count equals accepted symbols minus 16.
- **Reset mid-stream:** drop `reset_sig` for 1 cycle at symbol 100, then resume the stream with a freshly reset encoder.
  - Outputs are 0 and invalid immediately.
  - No valid output for the next 16 accepts.
  - Decoded bits match the post-reset input.
